tail_light: RTL and testbench
=============================

Name: tail_light

Overview:
- Moore FSM for a "Thunderbird-style" rear tail-light sequencer with three lamps per side: left LC LB LA, right RA RB RC.
- Inputs:
  - LEFT selects a sequential left-turn pattern.
  - RIGHT selects a sequential right-turn pattern.
  - HAZ, or LEFT and RIGHT together, flashes all six lamps.
- Sits at the top of the lighting controller and drives lamp drivers directly.

Parameters:
- TICK_DIV, default 1: clock cycles per FSM step.
  - Internal counter produces a one-cycle step enable every TICK_DIV cycles.
  - 1 means the FSM steps every clock.
  - Legal range is 1 to 2^24.

Ports:
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- LEFT  input  1  left-turn request, level sensitive
- RIGHT  input  1  right-turn request, level sensitive
- HAZ  input  1  hazard request, level sensitive
- LC  output  1  left outer lamp
- LB  output  1  left middle lamp
- LA  output  1  left inner lamp
- RA  output  1  right inner lamp
- RB  output  1  right middle lamp
- RC  output  1  right outer lamp

Behaviour:
- States: IDLE, L1, L2, L3, R1, R2, R3, LR3. Encoding is implementation choice.
- Reset (async, high):
  - state goes to IDLE, tick counter goes to 0, all six outputs are 0.
  - The first step enable occurs TICK_DIV cycles after reset deasserts.
- State changes only on a rising clk edge where the step enable is 1. Otherwise state holds.
- Inputs are sampled on step edges only. No synchronizers are inside the block.
- Transitions:
  - IDLE:
    - HAZ, or LEFT&RIGHT: go to LR3.
    - Else LEFT: go to L1.
    - Else RIGHT: go to R1.
    - Else stay in IDLE.
  - L1: HAZ goes to LR3, else L2.
  - L2: HAZ goes to LR3, else L3.
  - L3: go to IDLE unconditionally.
  - R1: HAZ goes to LR3, else R2.
  - R2: HAZ goes to LR3, else R3.
  - R3: go to IDLE unconditionally.
  - LR3: go to IDLE unconditionally.
  - Mid-sequence, a LEFT/RIGHT change does not abort; the sequence completes.
- Outputs are a pure decode of the state (Moore, no input-to-output path):
  - IDLE: all 0.
  - L1: LA.
  - L2: LA, LB.
  - L3: LA, LB, LC.
  - R1: RA.
  - R2: RA, RB.
  - R3: RA, RB, RC.
  - LR3: all six 1.
- Steady patterns with inputs held:
  - LEFT held: 4-step period L1, L2, L3, IDLE.
  - RIGHT held: 4-step period R1, R2, R3, IDLE.
  - HAZ held: 2-step period LR3, IDLE.
- Illegal or unused state encodings recover to IDLE on the next step with outputs 0.

Optional Feature:
- Macro TAILLIGHT_BRAKE_EN.
- When defined:
  - An extra input port BRAKE (1 bit) is added after HAZ.
  - While BRAKE is 1, the lamps of any side not currently in its turn sequence are forced fully on.
    - In IDLE: all six lamps on.
    - In L1..L3: RA, RB, RC forced on.
    - In R1..R3: LA, LB, LC forced on.
    - In LR3: all six lamps on (unchanged).
  - The FSM itself is unaffected.
- When undefined: no BRAKE port; outputs exactly as above.

Decomposition:
- Package tail_light_pkg holds:
  - the state enum typedef (IDLE..LR3);
  - a 6-bit lamp-vector typedef with field order LC, LB, LA, RA, RB, RC;
  - per-state lamp-pattern constants.
- One sub-module, tail_light_tick: parameterized TICK_DIV counter with async reset that emits the one-cycle step enable.

Test Plan:
- Reset, then LEFT=1, RIGHT=0, HAZ=0, TICK_DIV=1, for 10 clocks -> {LC,LB,LA} cycles 001, 011, 111, 000, repeating. Right lamps stay 0.
- LEFT=0, RIGHT=1, HAZ=0 -> {RA,RB,RC} cycles 100, 110, 111, 000. Left lamps stay 0.
- LEFT=0, RIGHT=0, HAZ=1 -> all six lamps alternate 111111, 000000 every clock.
- LEFT=1, HAZ=1; then separately LEFT=1, RIGHT=1, HAZ=0 -> both behave identically to hazard: LR3/IDLE alternation.
- In L2, assert HAZ for one step -> next state LR3 (all on), then IDLE. Also in L2, drop LEFT -> L3 still follows.
- Reset asserted asynchronously mid-L2 -> outputs 0 immediately, without waiting for an edge. With TICK_DIV=3, the step occurs every 3rd clock.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared types for the tail-light sequencer: FSM state encoding, lamp vector
// layout (LC LB LA RA RB RC, MSB first) and the per-state lamp patterns.
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  typedef struct packed {
    logic lc;
    logic lb;
    logic la;
    logic ra;
    logic rb;
    logic rc;
  } lamps_t;

  localparam lamps_t LAMPS_OFF   = 6'b000_000;
  localparam lamps_t LAMPS_L1    = 6'b001_000;
  localparam lamps_t LAMPS_L2    = 6'b011_000;
  localparam lamps_t LAMPS_L3    = 6'b111_000;
  localparam lamps_t LAMPS_R1    = 6'b000_100;
  localparam lamps_t LAMPS_R2    = 6'b000_110;
  localparam lamps_t LAMPS_R3    = 6'b000_111;
  localparam lamps_t LAMPS_ALL   = 6'b111_111;

  function automatic lamps_t lamps_of(input state_t s);
    lamps_t l;
    case (s)
      L1:      l = LAMPS_L1;
      L2:      l = LAMPS_L2;
      L3:      l = LAMPS_L3;
      R1:      l = LAMPS_R1;
      R2:      l = LAMPS_R2;
      R3:      l = LAMPS_R3;
      LR3:     l = LAMPS_ALL;
      default: l = LAMPS_OFF;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tail_light_tick.sv
// Step-enable generator: one-cycle pulse every TICK_DIV clocks, the first one
// in the TICK_DIV-th cycle after reset releases.
module tail_light_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign step = (cnt == LAST);

endmodule

// File: rtl/tail_light.sv
// Thunderbird-style tail-light Moore FSM. Optional macro TAILLIGHT_BRAKE_EN
// adds a BRAKE input that lights every side not running a turn sequence.
module tail_light
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic LEFT,
  input  logic RIGHT,
  input  logic HAZ,
`ifdef TAILLIGHT_BRAKE_EN
  input  logic BRAKE,
`endif
  output logic LC,
  output logic LB,
  output logic LA,
  output logic RA,
  output logic RB,
  output logic RC
);

  state_t state, nxt;
  logic   step;
  lamps_t lamps;

  tail_light_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .step  (step)
  );

  // Hazard wins over any in-progress turn until the last lamp is lit.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: begin
        if (HAZ || (LEFT && RIGHT)) nxt = LR3;
        else if (LEFT)              nxt = L1;
        else if (RIGHT)             nxt = R1;
        else                        nxt = IDLE;
      end
      L1:      nxt = HAZ ? LR3 : L2;
      L2:      nxt = HAZ ? LR3 : L3;
      L3:      nxt = IDLE;
      R1:      nxt = HAZ ? LR3 : R2;
      R2:      nxt = HAZ ? LR3 : R3;
      R3:      nxt = IDLE;
      LR3:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     state <= IDLE;
    else if (step) state <= nxt;
  end

`ifdef TAILLIGHT_BRAKE_EN
  always_comb begin
    lamps = lamps_of(state);
    if (BRAKE) begin
      case (state)
        L1, L2, L3: lamps = lamps | LAMPS_R3;
        R1, R2, R3: lamps = lamps | LAMPS_L3;
        default:    lamps = LAMPS_ALL;
      endcase
    end
  end
`else
  always_comb begin
    lamps = lamps_of(state);
  end
`endif

  assign LC = lamps.lc;
  assign LB = lamps.lb;
  assign LA = lamps.la;
  assign RA = lamps.ra;
  assign RB = lamps.rb;
  assign RC = lamps.rc;

endmodule

// File: tb/tb_tail_light.sv
// Directed bench for tail_light: TICK_DIV=1 instance for the sequences and an
// instance with TICK_DIV=3 for the step divider; lamps shown as LC..RC.
module tb_tail_light;

  logic clk = 1'b0;
  logic reset, left, right, haz;
`ifdef TAILLIGHT_BRAKE_EN
  logic brake;
`endif
  logic lc1, lb1, la1, ra1, rb1, rc1;
  logic lc3, lb3, la3, ra3, rb3, rc3;
  logic [5:0] lamps1, lamps3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign lamps1 = {lc1, lb1, la1, ra1, rb1, rc1};
  assign lamps3 = {lc3, lb3, la3, ra3, rb3, rc3};

  tail_light #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .LEFT(left), .RIGHT(right), .HAZ(haz),
`ifdef TAILLIGHT_BRAKE_EN
    .BRAKE(brake),
`endif
    .LC(lc1), .LB(lb1), .LA(la1), .RA(ra1), .RB(rb1), .RC(rc1)
  );

  tail_light #(.TICK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .LEFT(left), .RIGHT(right), .HAZ(haz),
`ifdef TAILLIGHT_BRAKE_EN
    .BRAKE(brake),
`endif
    .LC(lc3), .LB(lb3), .LA(la3), .RA(ra3), .RB(rb3), .RC(rc3)
  );

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reset pulse, then apply the new input levels as reset releases.
  task automatic restart(input logic l, input logic r, input logic h);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    left = l; right = r; haz = h;
    reset = 1'b0;
  endtask

  task automatic edge1(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #1;
    chk(tag, lamps1, exp);
  endtask

  logic [5:0] left_pat  [4];
  logic [5:0] right_pat [4];
  logic [5:0] haz_pat   [2];
  logic [5:0] div3_pat  [12];

  initial begin
    left_pat  = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
    right_pat = '{6'b000100, 6'b000110, 6'b000111, 6'b000000};
    haz_pat   = '{6'b111111, 6'b000000};
    div3_pat  = '{6'b000000, 6'b000000, 6'b001000,
                  6'b001000, 6'b001000, 6'b011000,
                  6'b011000, 6'b011000, 6'b111000,
                  6'b111000, 6'b111000, 6'b000000};

    reset = 1'b1; left = 1'b0; right = 1'b0; haz = 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
    brake = 1'b0;
`endif
    #1;
    chk("reset_async_div1", lamps1, 6'b000000);
    chk("reset_async_div3", lamps3, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", lamps1, 6'b000000);

    restart(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) edge1($sformatf("left_%0d", i), left_pat[i % 4]);

    restart(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) edge1($sformatf("right_%0d", i), right_pat[i % 4]);

    restart(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) edge1($sformatf("haz_%0d", i), haz_pat[i % 2]);

    restart(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) edge1($sformatf("left_haz_%0d", i), haz_pat[i % 2]);

    restart(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) edge1($sformatf("left_right_%0d", i), haz_pat[i % 2]);

    // Hazard interrupting L2.
    restart(1'b1, 1'b0, 1'b0);
    edge1("l2haz_l1", 6'b001000);
    edge1("l2haz_l2", 6'b011000);
    @(negedge clk); haz = 1'b1;
    edge1("l2haz_lr3", 6'b111111);
    @(negedge clk); haz = 1'b0; left = 1'b0;
    edge1("l2haz_idle", 6'b000000);
    edge1("l2haz_stay", 6'b000000);

    // Dropping LEFT in L2 still completes the sequence.
    restart(1'b1, 1'b0, 1'b0);
    edge1("l2drop_l1", 6'b001000);
    edge1("l2drop_l2", 6'b011000);
    @(negedge clk); left = 1'b0;
    edge1("l2drop_l3", 6'b111000);
    edge1("l2drop_idle", 6'b000000);
    edge1("l2drop_stay", 6'b000000);

    // Asynchronous reset while in L2, checked between clock edges.
    restart(1'b1, 1'b0, 1'b0);
    edge1("areset_l1", 6'b001000);
    edge1("areset_l2", 6'b011000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_now", lamps1, 6'b000000);
    @(negedge clk);
    reset = 1'b0; left = 1'b0;

    // Divide-by-3 stepping on the second instance.
    restart(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("div3_%0d", i), lamps3, div3_pat[i]);
    end

`ifdef TAILLIGHT_BRAKE_EN
    restart(1'b0, 1'b0, 1'b0);
    @(negedge clk); brake = 1'b1;
    #1 chk("brake_idle", lamps1, 6'b111111);
    @(negedge clk); left = 1'b1;
    edge1("brake_l1", 6'b001111);
    @(negedge clk); brake = 1'b0; left = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
